// File: rtl/data_bus_responder_if.sv
// Load/store bus between the core data port (master) and the responder (slave).
// The master holds req and all request fields until it sees the one-cycle ack.
interface data_bus_responder_if #(
  parameter int DATA_BITS = 32
);
  logic                 req;
  logic                 we;
  logic [3:0]           sel;
  logic [31:0]          addr;
  logic [DATA_BITS-1:0] wdata;
  logic                 ack;
  logic                 err;
  logic [DATA_BITS-1:0] rdata;

  modport master (output req, we, sel, addr, wdata, input ack, err, rdata);
  modport slave  (input req, we, sel, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/data_bus_responder.sv
// Data-bus target: word RAM plus DISPLAY/CYCLES/STATUS MMIO; DBUS_CYCLE_COUNTER_EN builds the cycle counter.
// Ack WAIT_STATES+1 cycles after capture; requests are held by the initiator, one transaction per WAIT_STATES+2 cycles.
module data_bus_responder #(
  parameter int MEM_ADDR    = 10,
  parameter int DATA_BITS   = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  data_bus_responder_if.slave  bus,
  output logic [DATA_BITS-1:0] disp_out,
  output logic                 disp_valid
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [29:0] DISP_W = 30'h3FFF_C000;
  localparam logic [29:0] CYC_W  = 30'h3FFF_C001;
  localparam logic [29:0] STAT_W = 30'h3FFF_C002;
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t               state_q, state_d;
  logic [3:0]           wcnt_q, wcnt_d;
  logic [29:0]          addr_q;
  logic                 we_q;
  logic [3:0]           sel_q;
  logic [DATA_BITS-1:0] wdata_q;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [DATA_BITS-1:0] disp_q;
  logic                 disp_vld_q;
  logic                 status_q;
  logic [DATA_BITS-1:0] cyc_val;
  logic [DATA_BITS-1:0] mem [2**MEM_ADDR];

  // On the capture edge with no wait states, the latched copy is not yet loaded.
  logic [29:0] cur_w;
  logic        cur_we;
  logic        cur_ram, cur_disp, cur_cyc, cur_stat, cur_err;
  logic [DATA_BITS-1:0] read_val;

  assign cur_w    = (state_q == S_IDLE) ? bus.addr[31:2] : addr_q;
  assign cur_we   = (state_q == S_IDLE) ? bus.we : we_q;
  assign cur_ram  = (cur_w[29:MEM_ADDR] == '0);
  assign cur_disp = (cur_w == DISP_W);
  assign cur_cyc  = (cur_w == CYC_W);
  assign cur_stat = (cur_w == STAT_W);
  assign cur_err  = !(cur_ram || cur_disp || cur_cyc || cur_stat);

  always_comb begin
    read_val = '0;
    if (cur_ram)       read_val = mem[cur_w[MEM_ADDR-1:0]];
    else if (cur_disp) read_val = disp_q;
    else if (cur_cyc)  read_val = cyc_val;
    else if (cur_stat) read_val = {{(DATA_BITS-1){1'b0}}, status_q};
  end

  always_comb begin
    logic enter_resp;
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: if (bus.req) begin
        if (WAIT_STATES > 0) begin
          state_d = S_WAIT;
          wcnt_d  = WS_LOAD;
        end else begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_WAIT: begin
        if (wcnt_q == 4'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      rdata_d = cur_we ? '0 : read_val;
      err_d   = cur_err;
    end
  end

  // Commit decode uses only the latched request, during RESP.
  logic commit, cm_ram, disp_wr, stat_rd;
  assign commit  = (state_q == S_RESP);
  assign cm_ram  = commit && we_q && (addr_q[29:MEM_ADDR] == '0);
  assign disp_wr = commit && we_q && (addr_q == DISP_W) && (sel_q != 4'b0000);
  assign stat_rd = commit && !we_q && (addr_q == STAT_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      disp_q     <= '0;
      disp_vld_q <= 1'b0;
      status_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      disp_vld_q <= disp_wr;
      if (state_q == S_IDLE && bus.req) begin
        addr_q  <= bus.addr[31:2];
        we_q    <= bus.we;
        sel_q   <= bus.sel;
        wdata_q <= bus.wdata;
      end
      for (int b = 0; b < DATA_BITS / 8; b++)
        if (disp_wr && sel_q[b]) disp_q[8*b +: 8] <= wdata_q[8*b +: 8];
      if (disp_wr)      status_q <= 1'b1;
      else if (stat_rd) status_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_BITS / 8; b++)
      if (cm_ram && sel_q[b]) mem[addr_q[MEM_ADDR-1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
  end

`ifdef DBUS_CYCLE_COUNTER_EN
  logic [DATA_BITS-1:0] cyc_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc_q <= '0;
    else     cyc_q <= cyc_q + 1'b1;
  end
  assign cyc_val = cyc_q;
`else
  assign cyc_val = '0;
`endif

  assign bus.ack    = (state_q == S_RESP);
  assign bus.err    = err_q;
  assign bus.rdata  = rdata_q;
  assign disp_out   = disp_q;
  assign disp_valid = disp_vld_q;
endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench: WAIT_STATES=1 instance for RAM/MMIO/reset cases, WAIT_STATES=0 instance for CYCLES timing.
module tb_data_bus_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_bus_responder_if #(.DATA_BITS(32)) bif ();
  data_bus_responder_if #(.DATA_BITS(32)) bif0 ();
  logic [31:0] disp_out, disp_out0;
  logic        disp_valid, disp_valid0;

  data_bus_responder #(.MEM_ADDR(10), .DATA_BITS(32), .WAIT_STATES(1)) dut (
    .clk(clk), .rst(rst), .bus(bif), .disp_out(disp_out), .disp_valid(disp_valid)
  );
  data_bus_responder #(.MEM_ADDR(10), .DATA_BITS(32), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bif0), .disp_out(disp_out0), .disp_valid(disp_valid0)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Starts at a negedge with the DUT idle; returns at the negedge of the idle cycle after ack.
  task automatic txn(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er, output int lat);
    bif.req = 1'b1; bif.we = w; bif.sel = s; bif.addr = a; bif.wdata = d;
    lat = -1; rd = '0; er = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bif.ack === 1'b1) begin
        lat = c; rd = bif.rdata; er = bif.err;
        break;
      end
    end
    bif.req = 1'b0; bif.we = 1'b0; bif.sel = '0; bif.addr = '0; bif.wdata = '0;
    if (lat < 0) check("ack_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  logic [31:0] rd, v1, v2;
  logic        er;
  int          lat, c1, c2, nack;

  initial begin
    rst = 1'b1;
    bif.req = 1'b0; bif.we = 1'b0; bif.sel = '0; bif.addr = '0; bif.wdata = '0;
    bif0.req = 1'b0; bif0.we = 1'b0; bif0.sel = '0; bif0.addr = '0; bif0.wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ack", {31'd0, bif.ack}, 32'd0);
    check("rst_err", {31'd0, bif.err}, 32'd0);
    check("rst_rdata", bif.rdata, 32'd0);
    check("rst_disp", disp_out, 32'd0);
    check("rst_dvld", {31'd0, disp_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    txn(1'b1, 4'b1111, 32'h0000_0010, 32'hDEAD_BEEF, rd, er, lat);
    check("st_lat", lat, 32'd2);
    check("st_err", {31'd0, er}, 32'd0);
    txn(1'b0, 4'b0000, 32'h0000_0010, 32'h0, rd, er, lat);
    check("ld_lat", lat, 32'd2);
    check("ld_data", rd, 32'hDEAD_BEEF);
    check("ld_err", {31'd0, er}, 32'd0);
    check("idle_ack", {31'd0, bif.ack}, 32'd0);
    check("idle_rdata", bif.rdata, 32'd0);

    txn(1'b1, 4'b0101, 32'h0000_0010, 32'h1122_3344, rd, er, lat);
    txn(1'b0, 4'b0000, 32'h0000_0013, 32'h0, rd, er, lat);
    check("lane_data", rd, 32'hDE22_BE44);
    txn(1'b1, 4'b0000, 32'h0000_0010, 32'hFFFF_FFFF, rd, er, lat);
    txn(1'b0, 4'b1111, 32'h0000_0010, 32'h0, rd, er, lat);
    check("sel0_nochg", rd, 32'hDE22_BE44);

    txn(1'b1, 4'b1111, 32'hFFFF_0000, 32'h0000_0034, rd, er, lat);
    check("disp_val", disp_out, 32'h34);
    check("disp_pulse", {31'd0, disp_valid}, 32'd1);
    @(negedge clk);
    check("disp_pulse_end", {31'd0, disp_valid}, 32'd0);
    txn(1'b0, 4'b0000, 32'hFFFF_0000, 32'h0, rd, er, lat);
    check("disp_rd", rd, 32'h34);
    txn(1'b0, 4'b0000, 32'hFFFF_0008, 32'h0, rd, er, lat);
    check("stat_rd1", rd, 32'h1);
    txn(1'b0, 4'b0000, 32'hFFFF_0008, 32'h0, rd, er, lat);
    check("stat_rd2", rd, 32'h0);
    txn(1'b1, 4'b1111, 32'hFFFF_0004, 32'h1234_5678, rd, er, lat);
    check("cyc_wr_err", {31'd0, er}, 32'd0);
    check("cyc_wr_lat", lat, 32'd2);

    txn(1'b1, 4'b1111, 32'h0000_0000, 32'h0BAD_F00D, rd, er, lat);
    txn(1'b0, 4'b0000, 32'h0000_1000, 32'h0, rd, er, lat);
    check("dec_err", {31'd0, er}, 32'd1);
    check("dec_rdata", rd, 32'd0);
    txn(1'b1, 4'b1111, 32'h0000_1000, 32'hFFFF_FFFF, rd, er, lat);
    check("dec_st_err", {31'd0, er}, 32'd1);
    txn(1'b0, 4'b0000, 32'h0000_0000, 32'h0, rd, er, lat);
    check("dec_word0", rd, 32'h0BAD_F00D);
    txn(1'b0, 4'b0000, 32'hFFFF_000C, 32'h0, rd, er, lat);
    check("dec_mmio_err", {31'd0, er}, 32'd1);

    txn(1'b1, 4'b1111, 32'h0000_0020, 32'hA5A5_A5A5, rd, er, lat);
    bif.req = 1'b1; bif.we = 1'b1; bif.sel = 4'b1111; bif.addr = 32'h20; bif.wdata = 32'h1234_5678;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_ack", {31'd0, bif.ack}, 32'd0);
    check("mid_err", {31'd0, bif.err}, 32'd0);
    check("mid_rdata", bif.rdata, 32'd0);
    check("mid_disp", disp_out, 32'd0);
    check("mid_dvld", {31'd0, disp_valid}, 32'd0);
    nack = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bif.ack === 1'b1) nack++;
    end
    bif.req = 1'b0;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bif.ack === 1'b1) nack++;
    end
    check("mid_no_ack", nack, 32'd0);
    txn(1'b0, 4'b0000, 32'h0000_0020, 32'h0, rd, er, lat);
    check("mid_word", rd, 32'hA5A5_A5A5);

    bif0.req = 1'b1; bif0.we = 1'b0; bif0.sel = '0; bif0.addr = 32'hFFFF_0004;
    c1 = -1; c2 = -1; v1 = '0; v2 = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bif0.ack === 1'b1) begin
        if (c1 < 0) begin
          c1 = c; v1 = bif0.rdata;
        end else begin
          c2 = c; v2 = bif0.rdata;
          bif0.req = 1'b0;
          break;
        end
      end
    end
    bif0.req = 1'b0;
    check("ws0_lat", c1, 32'd1);
    check("ws0_gap", c2 - c1, 32'd2);
`ifdef DBUS_CYCLE_COUNTER_EN
    check("cyc_diff", v2 - v1, 32'd2);
    force dut0.cyc_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut0.cyc_q;
    @(negedge clk);
    check("cyc_wrap", dut0.cyc_q, 32'd0);
`else
    check("cyc_zero1", v1, 32'd0);
    check("cyc_zero2", v2, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/data_bus_responder.md
# data_bus_responder

Responder end of the CPU's data-memory bus: accepts load/store requests from the core, serves them from an internal word RAM or a small memory-mapped I/O window, and answers with a registered acknowledge after a fixed number of wait states. It sits between the core's data port and the seven-segment display path. It replaces the syscall-34 LED register with a memory-mapped display register, and adds a cycle counter and a status register. It is the bus target for the multi-cycle core, which holds each request until acknowledged.

## Interface
- MEM_ADDR, 10, RAM word-address bits (RAM depth 2^MEM_ADDR words)
- DATA_BITS, 32, data width (only 32 is supported)
- WAIT_STATES, 1, extra cycles between request capture and ack (0..15)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  1  request strobe from initiator
- we  in  1  1 = store, 0 = load
- sel  in  4  byte-lane enables for stores, bit i = byte i (little-endian)
- addr  in  32  byte address; bits [1:0] ignored
- wdata  in  32  store data
- ack  out  1  one-cycle response pulse
- err  out  1  asserted with ack on decode error
- rdata  out  32  load data, valid only while ack=1
- disp_out  out  32  display register, feeds the seven-segment driver
- disp_valid  out  1  one-cycle pulse the cycle after disp_out changes

## Operation
- Address map:
  - RAM: addr[31:MEM_ADDR+2]==0; word index addr[MEM_ADDR+1:2].
  - 0xFFFF0000 DISPLAY: R/W; a write updates disp_out under sel.
  - 0xFFFF0004 CYCLES: read only; writes are ignored and complete without err.
  - 0xFFFF0008 STATUS: read only; bit0 = DISPLAY written since the last STATUS read; bits 31:1 read 0; bit0 clears on read.
  - Any other address: err=1, no state change, rdata=0.
- FSM states:
  - IDLE: when req=1, latch addr, we, sel and wdata. Go to WAIT if WAIT_STATES>0 (load wait counter with WAIT_STATES-1), else go to RESP.
  - WAIT: decrement the wait counter; at 0, go to RESP.
  - RESP: ack=1 for exactly one cycle, then go to IDLE.
- A store commits on the clock edge that ends RESP. Only lanes with sel=1 are written. sel=0000 completes normally with no change.
- Loads return the full word and ignore sel. RAM and MMIO are sampled on entry to RESP and held in rdata for the ack cycle.
- Initiator rule: hold req and all fields until ack. The latched copy is authoritative: deasserting req or changing fields after capture does not affect the transaction.
- req is ignored outside IDLE. The cycle after ack is IDLE, so back-to-back throughput is one transaction per WAIT_STATES+2 cycles.
- Outside the ack cycle, rdata and err are 0.

## Timing
- Reset values:
  - Outputs: ack=0, err=0, rdata=0, disp_out=0, disp_valid=0.
  - Internal: state IDLE, STATUS bit0=0, cycle counter 0.
  - RAM contents are not cleared.
- Reset asserted mid-transaction abandons it: no write, no ack.
- Load latency: req sampled at edge N (IDLE), ack high during cycle N+1+WAIT_STATES.
- disp_out changes at the store-commit edge. disp_valid is high during the following cycle.
- Cycle counter: 32-bit, increments every clk, wraps 0xFFFFFFFF to 0. A CYCLES load returns the value at the RESP-entry edge.
- STATUS bit0 set and clear are both caused by transactions, so they never coincide.

## Configuration
- DBUS_CYCLE_COUNTER_EN defined: the CYCLES register and its 32-bit counter are built as described above.
- DBUS_CYCLE_COUNTER_EN undefined: no counter logic. CYCLES reads return 0 with err=0, and writes to it are ignored.

## Test plan
- Reset, WAIT_STATES=1: store 0xDEADBEEF to 0x00000010 with sel=1111, then load it. Required: ack 2 cycles after each req capture; load rdata=0xDEADBEEF, err=0.
- Byte lanes: store 0x11223344 to 0x10 with sel=0101, following the first test. Required: load of 0x10 returns 0xDE22BE44.
- DISPLAY/STATUS: store 0x00000034 to 0xFFFF0000, then load STATUS twice. Required: disp_out=0x34 with a disp_valid pulse the cycle after commit; STATUS reads 0x1 then 0x0.
- Decode error: load from 0x00001000 (MEM_ADDR=10). Required: ack=1 with err=1 and rdata=0. A store to the same address must not alter RAM word 0.
- Reset mid-transaction: assert rst during WAIT of a store to 0x20. Required: no ack; word 0x20 unchanged; all outputs 0.
- Counter, macro defined: load CYCLES twice back-to-back, WAIT_STATES=0. Required: second value minus first = 2. Also force the counter to 0xFFFFFFFF and check it wraps to 0. With the macro undefined, CYCLES reads 0.
